// File: rtl/arm_mem_pkg.sv
// Shared types and address helpers for the MEM-stage cache/SRAM path.
package arm_mem_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_LO,
        S_RD_HI,
        S_WR_LO,
        S_WR_HI,
        S_DONE
    } state_t;

    localparam int          SRAM_ADDR_W   = 18;
    localparam int          SRAM_DATA_W   = 16;
    localparam int          WORD_W        = SRAM_ADDR_W - 1;
    localparam logic [31:0] DEF_ADDR_BASE = 32'd1024;

    // Word number inside SRAM; wraps modulo 2^WORD_W.
    function automatic logic [WORD_W-1:0] addr_word(input logic [31:0] addr,
                                                    input logic [31:0] base);
        logic [31:0] off;
        off = addr - base;
        return WORD_W'(off >> 2);
    endfunction

    // Low idx_w bits of the word select the line.
    function automatic logic [WORD_W-1:0] word_index(input logic [WORD_W-1:0] word,
                                                     input int idx_w);
        return word & ((WORD_W'(1) << idx_w) - WORD_W'(1));
    endfunction

    // Remaining upper bits form the tag.
    function automatic logic [WORD_W-1:0] word_tag(input logic [WORD_W-1:0] word,
                                                   input int idx_w);
        return word >> idx_w;
    endfunction

endpackage

// File: rtl/mem_cache_unit_if.sv
// Pipeline-side request/response bundle of the MEM-stage memory port.
interface mem_cache_unit_if;
    logic        cache_en;
    logic        MEM_R_EN;
    logic        MEM_W_EN;
    logic [31:0] address;
    logic [31:0] data;
    logic [31:0] MEM_result;
    logic        ready;

    modport master (output cache_en, MEM_R_EN, MEM_W_EN, address, data,
                    input  MEM_result, ready);
    modport slave  (input  cache_en, MEM_R_EN, MEM_W_EN, address, data,
                    output MEM_result, ready);
endinterface

// File: rtl/cache_line_array.sv
// Direct-mapped line storage: valid/tag/data, async read, one sync write port.
module cache_line_array #(
    parameter int LINES = 64,
    parameter int TAG_W = 11
) (
    input  logic                     clk,
    input  logic                     i_clr,
    input  logic [$clog2(LINES)-1:0] i_rd_idx,
    output logic                     o_rd_valid,
    output logic [TAG_W-1:0]         o_rd_tag,
    output logic [31:0]              o_rd_data,
    input  logic                     i_we,
    input  logic [$clog2(LINES)-1:0] i_wr_idx,
    input  logic [TAG_W-1:0]         i_wr_tag,
    input  logic [31:0]              i_wr_data
);
    logic [LINES-1:0] r_valid;
    logic [TAG_W-1:0] r_tag  [LINES];
    logic [31:0]      r_data [LINES];

    // Valid bits: clear wins over a same-cycle write so no partial line survives.
    always_ff @(posedge clk) begin
        if (i_clr)
            r_valid <= '0;
        else if (i_we)
            r_valid[i_wr_idx] <= 1'b1;
    end

    // Tag/data payload; left unreset, guarded by the valid bits.
    always_ff @(posedge clk) begin
        if (i_we && !i_clr) begin
            r_tag[i_wr_idx]  <= i_wr_tag;
            r_data[i_wr_idx] <= i_wr_data;
        end
    end

    assign o_rd_valid = r_valid[i_rd_idx];
    assign o_rd_tag   = r_tag[i_rd_idx];
    assign o_rd_data  = r_data[i_rd_idx];
endmodule

// File: rtl/mem_cache_unit.sv
// MEM-stage 32-bit port: write-through read cache over a 16-bit SRAM.
module mem_cache_unit
    import arm_mem_pkg::*;
#(
    parameter int          LINES       = 64,
    parameter int          WAIT_CYCLES = 4,
    parameter logic [31:0] ADDR_BASE   = DEF_ADDR_BASE
) (
    input  logic                   clk,
    input  logic                   rst,
    mem_cache_unit_if.slave        bus,
    inout  wire  [SRAM_DATA_W-1:0] SRAM_DQ,
    output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
    output logic                   SRAM_UB_EN,
    output logic                   SRAM_LB_EN,
    output logic                   SRAM_CE_EN,
    output logic                   SRAM_WE_EN,
    output logic                   SRAM_OE_EN
);
    localparam int             IDX_W = $clog2(LINES);
    localparam int             TAG_W = WORD_W - IDX_W;
    localparam int             CNT_W = $clog2(WAIT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WAIT_CYCLES - 1);

    state_t           r_state, w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_fill;

    logic [WORD_W-1:0] w_word;
    logic [IDX_W-1:0]  w_index;
    logic [TAG_W-1:0]  w_tag;
    logic              w_line_valid;
    logic [TAG_W-1:0]  w_line_tag;
    logic [31:0]       w_line_data;
    logic              w_tag_hit, w_rd_hit, w_last, w_phase;
    logic              w_we;
    logic [31:0]       w_wr_data;
    logic              w_dq_drive;
    logic [15:0]       w_dq_out;

    assign w_word  = addr_word(bus.address, ADDR_BASE);
    assign w_index = IDX_W'(word_index(w_word, IDX_W));
    assign w_tag   = TAG_W'(word_tag(w_word, IDX_W));

    assign w_tag_hit = w_line_valid && (w_line_tag == w_tag);
    assign w_rd_hit  = bus.cache_en && w_tag_hit;
    assign w_last    = (r_cnt == LAST);
    assign w_phase   = (r_state == S_RD_LO) || (r_state == S_RD_HI) ||
                       (r_state == S_WR_LO) || (r_state == S_WR_HI);

    // Fill on the last RD_HI cycle (cache enabled); write-through update only on a hit.
    assign w_we      = ((r_state == S_RD_HI) && w_last && bus.cache_en) ||
                       ((r_state == S_WR_HI) && w_last && w_tag_hit);
    assign w_wr_data = (r_state == S_RD_HI) ? {SRAM_DQ, r_fill[15:0]} : bus.data;

    cache_line_array #(.LINES(LINES), .TAG_W(TAG_W)) u_lines (
        .clk       (clk),
        .i_clr     (rst),
        .i_rd_idx  (w_index),
        .o_rd_valid(w_line_valid),
        .o_rd_tag  (w_line_tag),
        .o_rd_data (w_line_data),
        .i_we      (w_we),
        .i_wr_idx  (w_index),
        .i_wr_tag  (w_tag),
        .i_wr_data (w_wr_data)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Phase counter: counts WAIT_CYCLES cycles per SRAM halfword phase.
    always_ff @(posedge clk) begin
        if (rst || !w_phase) r_cnt <= '0;
        else if (w_last)     r_cnt <= '0;
        else                 r_cnt <= r_cnt + 1'b1;
    end

    // Fill register: capture each halfword on the last cycle of its phase.
    always_ff @(posedge clk) begin
        if (rst)
            r_fill <= '0;
        else if (r_state == S_RD_LO && w_last)
            r_fill[15:0] <= SRAM_DQ;
        else if (r_state == S_RD_HI && w_last)
            r_fill[31:16] <= SRAM_DQ;
    end

    // Next-state logic; writes win when both enables are set.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.MEM_W_EN)                  w_next = S_WR_LO;
                else if (bus.MEM_R_EN && !w_rd_hit) w_next = S_RD_LO;
            end
            S_RD_LO: if (w_last) w_next = S_RD_HI;
            S_RD_HI: if (w_last) w_next = S_DONE;
            S_WR_LO: if (w_last) w_next = S_WR_HI;
            S_WR_HI: if (w_last) w_next = S_DONE;
            S_DONE:              w_next = S_IDLE;
            default:             w_next = S_IDLE;
        endcase
    end

    // Outputs decoded from state: handshake, result mux and SRAM pins.
    always_comb begin
        bus.ready      = 1'b0;
        bus.MEM_result = '0;
        SRAM_ADDR      = '0;
        SRAM_WE_EN     = 1'b1;
        SRAM_OE_EN     = 1'b1;
        w_dq_drive     = 1'b0;
        w_dq_out       = '0;
        case (r_state)
            S_IDLE: begin
                bus.ready = !(bus.MEM_W_EN || (bus.MEM_R_EN && !w_rd_hit));
                if (bus.MEM_R_EN && !bus.MEM_W_EN && w_rd_hit)
                    bus.MEM_result = w_line_data;
            end
            S_RD_LO: begin
                SRAM_ADDR  = {w_word, 1'b0};
                SRAM_OE_EN = 1'b0;
            end
            S_RD_HI: begin
                SRAM_ADDR  = {w_word, 1'b1};
                SRAM_OE_EN = 1'b0;
            end
            S_WR_LO: begin
                SRAM_ADDR  = {w_word, 1'b0};
                SRAM_WE_EN = 1'b0;
                w_dq_drive = 1'b1;
                w_dq_out   = bus.data[15:0];
            end
            S_WR_HI: begin
                SRAM_ADDR  = {w_word, 1'b1};
                SRAM_WE_EN = 1'b0;
                w_dq_drive = 1'b1;
                w_dq_out   = bus.data[31:16];
            end
            S_DONE: begin
                bus.ready      = 1'b1;
                bus.MEM_result = r_fill;
            end
            default: ;
        endcase
    end

    assign SRAM_DQ    = w_dq_drive ? w_dq_out : {SRAM_DATA_W{1'bz}};
    assign SRAM_UB_EN = 1'b0;
    assign SRAM_LB_EN = 1'b0;
    assign SRAM_CE_EN = 1'b0;
endmodule

// File: tb/tb_mem_cache_unit.sv
// Bench for mem_cache_unit: vector table + scoreboard queue + reset corner case.
module tb_mem_cache_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        preload;
    wire  [15:0] SRAM_DQ;
    logic [17:0] SRAM_ADDR;
    logic        SRAM_UB_EN, SRAM_LB_EN, SRAM_CE_EN, SRAM_WE_EN, SRAM_OE_EN;
    logic [15:0] sram [0:1023];

    int n_tests = 0;
    int n_fail  = 0;

    mem_cache_unit_if bus();

    mem_cache_unit #(.LINES(64), .WAIT_CYCLES(4), .ADDR_BASE(32'd1024)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .SRAM_DQ   (SRAM_DQ),
        .SRAM_ADDR (SRAM_ADDR),
        .SRAM_UB_EN(SRAM_UB_EN),
        .SRAM_LB_EN(SRAM_LB_EN),
        .SRAM_CE_EN(SRAM_CE_EN),
        .SRAM_WE_EN(SRAM_WE_EN),
        .SRAM_OE_EN(SRAM_OE_EN)
    );

    always #5 clk = ~clk;

    // SRAM model: drives the bus on reads, captures on writes.
    assign SRAM_DQ = (!SRAM_OE_EN && SRAM_WE_EN) ? sram[SRAM_ADDR[9:0]] : 16'hzzzz;

    always @(posedge clk) begin
        if (preload) begin
            sram[0]   <= 16'h5678;  sram[1]   <= 16'h1234;
            sram[2]   <= 16'hC0DE;  sram[3]   <= 16'hF00D;
            sram[128] <= 16'hAAAA;  sram[129] <= 16'h5555;
        end else if (!SRAM_WE_EN) begin
            sram[SRAM_ADDR[9:0]] <= SRAM_DQ;
        end
    end

    typedef struct {
        string       nm;
        logic [31:0] res;
        int          low;
        logic        is_rd;
    } exp_t;

    typedef struct {
        logic        en;
        logic        rd;
        logic        wr;
        logic [31:0] a;
        logic [31:0] d;
        int          low;
        logic [31:0] res;
        string       nm;
    } vec_t;

    exp_t sb[$];
    vec_t vt[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic add(input logic en, input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] d, input int low, input logic [31:0] res,
                       input string nm);
        vec_t v;
        v.en = en; v.rd = rd; v.wr = wr; v.a = a; v.d = d;
        v.low = low; v.res = res; v.nm = nm;
        vt.push_back(v);
    endtask

    // One request: push expectation, hold request until ready, pop and compare.
    task automatic txn(input logic en, input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] d, input int low, input logic [31:0] res,
                       input string nm);
        exp_t        e;
        int          cnt;
        logic        pin_bad;
        logic        hi;
        logic        is_wr;
        logic [16:0] w;
        logic [17:0] ea;
        e.nm = nm; e.res = res; e.low = low; e.is_rd = rd && !wr;
        sb.push_back(e);
        is_wr = wr;
        w = 17'((a - 32'd1024) >> 2);
        @(posedge clk); #1;
        bus.cache_en = en; bus.MEM_R_EN = rd; bus.MEM_W_EN = wr;
        bus.address = a;   bus.data = d;
        cnt = 0; pin_bad = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.ready) break;
            if (cnt == 0) begin
                if (SRAM_WE_EN !== 1'b1 || SRAM_OE_EN !== 1'b1) pin_bad = 1'b1;
            end else if (cnt <= 8) begin
                hi = (cnt >= 5);
                ea = {w, hi};
                if (SRAM_ADDR !== ea) pin_bad = 1'b1;
                if (is_wr) begin
                    if (SRAM_WE_EN !== 1'b0 || SRAM_OE_EN !== 1'b1) pin_bad = 1'b1;
                    if (SRAM_DQ !== (hi ? d[31:16] : d[15:0])) pin_bad = 1'b1;
                end else begin
                    if (SRAM_WE_EN !== 1'b1 || SRAM_OE_EN !== 1'b0) pin_bad = 1'b1;
                end
            end
            cnt++;
            if (cnt > 40) break;
        end
        if (SRAM_WE_EN !== 1'b1) pin_bad = 1'b1;
        e = sb.pop_front();
        chk({e.nm, " stall"}, 32'(cnt), 32'(e.low));
        if (e.is_rd) chk({e.nm, " data"}, bus.MEM_result, e.res);
        if (e.low == 0) chk({e.nm, " no_sram"}, {31'b0, SRAM_OE_EN}, 32'd1);
        else            chk({e.nm, " pins"}, {31'b0, pin_bad}, 32'd0);
        @(posedge clk); #1;
        bus.MEM_R_EN = 1'b0; bus.MEM_W_EN = 1'b0;
    endtask

    initial begin
        bus.cache_en = 1'b1; bus.MEM_R_EN = 1'b0; bus.MEM_W_EN = 1'b0;
        bus.address = 32'd1024; bus.data = '0;
        rst = 1'b1; preload = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0; preload = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst ready",  {31'b0, bus.ready}, 32'd1);
        chk("rst result", bus.MEM_result, 32'd0);
        chk("rst we",     {31'b0, SRAM_WE_EN}, 32'd1);
        chk("rst oe",     {31'b0, SRAM_OE_EN}, 32'd1);
        chk("rst addr",   {14'b0, SRAM_ADDR}, 32'd0);
        chk("rst ties",   {29'b0, SRAM_UB_EN, SRAM_LB_EN, SRAM_CE_EN}, 32'd0);
        n_tests++;
        if (SRAM_DQ !== 16'hzzzz) begin
            n_fail++;
            $display("FAIL rst dq: got %h, expected zzzz", SRAM_DQ);
        end

        //   en    rd    wr    addr     data          low res            name
        add(1'b1, 1'b1, 1'b0, 32'd1024, 32'h0,         9, 32'h12345678, "miss0");
        add(1'b1, 1'b1, 1'b0, 32'd1024, 32'h0,         0, 32'h12345678, "hit0");
        add(1'b1, 1'b0, 1'b1, 32'd1024, 32'hDEADBEEF,  9, 32'h0,        "wr_hit");
        add(1'b1, 1'b1, 1'b0, 32'd1024, 32'h0,         0, 32'hDEADBEEF, "hit_after_wr");
        add(1'b1, 1'b1, 1'b0, 32'd1280, 32'h0,         9, 32'h5555AAAA, "conflict");
        add(1'b1, 1'b1, 1'b0, 32'd1024, 32'h0,         9, 32'hDEADBEEF, "refetch");
        add(1'b1, 1'b1, 1'b0, 32'd1024, 32'h0,         0, 32'hDEADBEEF, "hit_again");
        add(1'b0, 1'b1, 1'b0, 32'd1024, 32'h0,         9, 32'hDEADBEEF, "bypass1");
        add(1'b0, 1'b1, 1'b0, 32'd1024, 32'h0,         9, 32'hDEADBEEF, "bypass2");
        add(1'b0, 1'b1, 1'b0, 32'd1028, 32'h0,         9, 32'hF00DC0DE, "bypass_new");
        add(1'b1, 1'b1, 1'b0, 32'd1028, 32'h0,         9, 32'hF00DC0DE, "nofill_check");
        add(1'b1, 1'b0, 1'b1, 32'd1284, 32'h11112222,  9, 32'h0,        "wr_conflict");
        add(1'b1, 1'b1, 1'b0, 32'd1028, 32'h0,         0, 32'hF00DC0DE, "no_invalidate");
        add(1'b1, 1'b1, 1'b0, 32'd1284, 32'h0,         9, 32'h11112222, "wr_noalloc");
        add(1'b1, 1'b1, 1'b1, 32'd1284, 32'h33334444,  9, 32'h0,        "rw_is_write");
        add(1'b1, 1'b1, 1'b0, 32'd1284, 32'h0,         0, 32'h33334444, "hit_rw");

        foreach (vt[i])
            txn(vt[i].en, vt[i].rd, vt[i].wr, vt[i].a, vt[i].d, vt[i].low, vt[i].res, vt[i].nm);

        // Reset during RD_HI: 1280 misses (index 0 holds 1024)
        @(posedge clk); #1;
        bus.cache_en = 1'b1; bus.MEM_R_EN = 1'b1; bus.MEM_W_EN = 1'b0; bus.address = 32'd1280;
        repeat (6) @(posedge clk);
        #1 rst = 1'b1; bus.MEM_R_EN = 1'b0;
        @(negedge clk);
        chk("mid in_rd_hi oe", {31'b0, SRAM_OE_EN}, 32'd0);
        chk("mid in_rd_hi addr", {14'b0, SRAM_ADDR}, 32'd129);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("mid ready", {31'b0, bus.ready}, 32'd1);
        chk("mid we",    {31'b0, SRAM_WE_EN}, 32'd1);
        chk("mid oe",    {31'b0, SRAM_OE_EN}, 32'd1);
        chk("mid addr",  {14'b0, SRAM_ADDR}, 32'd0);
        txn(1'b1, 1'b1, 1'b0, 32'd1024, 32'h0, 9, 32'hDEADBEEF, "post_rst_1024");
        txn(1'b1, 1'b1, 1'b0, 32'd1284, 32'h0, 9, 32'h33334444, "post_rst_1284");
        txn(1'b1, 1'b1, 1'b0, 32'd1280, 32'h0, 9, 32'h5555AAAA, "post_rst_1280");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_cache_unit.md
# mem_cache_unit

Parametrised successor to the MEM-stage SRAM path of the ARM pipeline: a 32-bit data port for the MEM stage, backed by a direct-mapped, write-through read cache in front of the 16-bit external SRAM. It issues two-halfword SRAM transactions with a configurable number of wait cycles. It drives `ready`, which the pipeline uses to freeze the IF, ID, EXE and MEM stage registers while a memory transaction is in flight. Sits between the EXE/MEM stage register and the MEM/WB stage register.

## Interface
- `LINES`, 64: cache lines, one 32-bit word each. Must be a power of two, range 4..1024.
- `WAIT_CYCLES`, 4: cycles each SRAM halfword phase is held. Minimum 1.
- `ADDR_BASE`, 1024: byte offset subtracted from `address` before mapping to SRAM.
- `clk` in 1: the only clock. All logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cache_en` in 1: 0 = bypass mode. Every read goes to SRAM and nothing is filled.
- `MEM_R_EN` in 1: read request, level-held.
- `MEM_W_EN` in 1: write request, level-held.
- `address` in 32: byte address.
- `data` in 32: store data.
- `MEM_result` out 32: load data.
- `ready` out 1: 1 = request complete or no request pending.
- `SRAM_DQ` inout 16: SRAM data bus.
- `SRAM_ADDR` out 18: SRAM halfword address.
- `SRAM_UB_EN`, `SRAM_LB_EN`, `SRAM_CE_EN` out 1 each: active-low. Tied to 0.
- `SRAM_WE_EN` out 1: active-low write enable.
- `SRAM_OE_EN` out 1: active-low output enable.

## Operation
- **Address mapping.**
  - `word = (address - ADDR_BASE) >> 2`, truncated to 17 bits, so it wraps modulo 2^17.
  - Low halfword is at `{word,0}`; high halfword is at `{word,1}`.
  - `index = word[log2(LINES)-1:0]`; `tag` is the remaining upper bits of `word`.
- **Requests.**
  - Both enables asserted at once is treated as a write.
  - Requests are sampled only in IDLE. Inputs are stable while `ready` = 0, because the pipeline is frozen.
- **States:** IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE.
- **IDLE.**
  - No request: `ready` = 1.
  - Read hit (`cache_en`, valid, tag match): `ready` = 1 and `MEM_result` = line data, combinationally, in the same cycle. State stays IDLE.
  - Read miss: `ready` = 0, go to RD_LO.
  - Write: `ready` = 0, go to WR_LO.
- **RD_LO** (`WAIT_CYCLES` cycles): `SRAM_ADDR` = low address, `SRAM_OE_EN` = 0. The last cycle latches `SRAM_DQ` into fill[15:0]. Then go to RD_HI.
- **RD_HI:** same as RD_LO for the high address; latches fill[31:16]. Then go to DONE.
  - If `cache_en` = 1, the last cycle writes valid/tag/data at `index`.
- **WR_LO / WR_HI** (`WAIT_CYCLES` cycles each):
  - `SRAM_ADDR` = low or high address; `SRAM_WE_EN` = 0.
  - `SRAM_DQ` is driven with `data[15:0]` or `data[31:16]`. It is high-Z in every other state.
  - Write-through, no write-allocate: on a hit, the line data is updated in the last WR_HI cycle. On a miss, the cache is unchanged.
- **DONE** (1 cycle): `ready` = 1. For a read, `MEM_result` = fill register. Then go to IDLE unconditionally, so a held request is not re-issued.
- A write to the same index with a different tag does not invalidate the line.
- `cache_en` 1→0 leaves the lines intact. Cached data goes stale only if SRAM changes outside this block.

## Timing
- **Reset values:**
  - State IDLE; all valid bits 0; fill register 0.
  - `ready` = 1, `MEM_result` = 0.
  - `SRAM_WE_EN` = 1, `SRAM_OE_EN` = 1, `SRAM_ADDR` = 0, `SRAM_DQ` high-Z.
- **Latency:**
  - Read hit: 0 extra cycles.
  - Read miss or write: `ready` is low for exactly 1 + 2·`WAIT_CYCLES` cycles, then high for one cycle in DONE. This is 9 low cycles at the default.
- **Reset mid-transaction:** the next cycle is IDLE, `SRAM_WE_EN` = 1, the cache is fully invalid and no partial line is written. A partial SRAM write may remain in SRAM.
- `SRAM_ADDR` changes only on a phase boundary. `SRAM_WE_EN` deasserts in the same edge that `SRAM_ADDR` changes.

## Structure
- **Package `arm_mem_pkg`:**
  - State enum.
  - `SRAM_ADDR_W` = 18, `SRAM_DATA_W` = 16.
  - Default `ADDR_BASE`.
  - Functions for the word/index/tag split.
- **Sub-module `cache_line_array`** (parameter `LINES`):
  - Valid, tag and data storage.
  - Combinational read port, one synchronous write port.
  - Synchronous clear of all valid bits.
- **Top:** FSM, phase counter (`$clog2(WAIT_CYCLES+1)` bits), fill register and SRAM pin drivers.

## Test plan
- **Reset, then read miss:** SRAM at halfwords 0/1 = 16'h5678/16'h1234, read of `address` 1024. Expect `ready` low for 9 cycles, then `MEM_result` = 32'h12345678 in DONE.
- **Repeat read hit:** same read again. Expect `ready` = 1 throughout and `MEM_result` = 32'h12345678 in the same cycle, with no SRAM activity (`SRAM_OE_EN` stays 1).
- **Write-through on a hit:** write 32'hDEADBEEF to 1024. Expect `SRAM_WE_EN` low for 2×4 cycles at halfword addresses 0 then 1, with SRAM_DQ = 16'hBEEF then 16'hDEAD. A following read hits and returns 32'hDEADBEEF.
- **Conflict miss:** with `LINES` = 64, read 1024 + 256 (same index, different tag). Expect a miss, 9 stall cycles and replacement of the line. A read of 1024 then misses again.
- **Bypass mode:** `cache_en` = 0, two reads of a cached address. Expect both to take 9 stall cycles, with no cache update.
- **Reset during RD_HI:** assert `rst` during RD_HI. Expect IDLE, `ready` = 1 and all lines invalid next cycle; a subsequent read of the same address misses.
